// File: rtl/rename_reg_file_mc.sv
// Architectural register file with per-register rename tags, multi-lane commit,
// same-cycle commit-to-read bypass and mispredict flush of all renames.
module rename_reg_file_mc #(
    parameter int XLEN         = 32,
    parameter int REG_NUM      = 32,
    parameter int ROB_W        = 4,
    parameter int COMMIT_LANES = 2,
    localparam int RI_W        = $clog2(REG_NUM)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic                         jump_wrong,
    input  logic                         dec_valid,
    input  logic [RI_W-1:0]              dec_rs1_idx,
    input  logic [RI_W-1:0]              dec_rs2_idx,
    input  logic                         dec_need_rs1,
    input  logic                         dec_need_rs2,
    input  logic [RI_W-1:0]              dec_rd_idx,
    input  logic                         dec_has_rd,
    input  logic [ROB_W-1:0]             dec_rob_tag,
    output logic                         rsp_valid,
    output logic [XLEN-1:0]              rsp_rs1_value,
    output logic                         rsp_rs1_busy,
    output logic [ROB_W-1:0]             rsp_rs1_tag,
    output logic [XLEN-1:0]              rsp_rs2_value,
    output logic                         rsp_rs2_busy,
    output logic [ROB_W-1:0]             rsp_rs2_tag,
    input  logic [COMMIT_LANES-1:0]      cm_en,
    input  logic [COMMIT_LANES*RI_W-1:0] cm_idx,
    input  logic [COMMIT_LANES*ROB_W-1:0] cm_tag,
    input  logic [COMMIT_LANES*XLEN-1:0] cm_value
);

    typedef struct packed {
        logic [XLEN-1:0]  value;
        logic             busy;
        logic [ROB_W-1:0] tag;
    } opnd_t;

    logic [REG_NUM-1:0][XLEN-1:0]  val_q, val_n;
    logic [REG_NUM-1:0]            busy_q, busy_n;
    logic [REG_NUM-1:0][ROB_W-1:0] tag_q, tag_n;

    logic  accept;
    opnd_t rs1_op, rs2_op;
    opnd_t rs1_p1, rs2_p1;
    logic  vld_p1;
    logic [RI_W-1:0]  ci;
    logic [ROB_W-1:0] ct;

    assign accept = dec_valid & ~jump_wrong;

    // Lookup against pre-update state; a committing producer whose tag still
    // owns the register forwards its value, highest lane last so it wins.
    function automatic opnd_t lookup(
        input logic [RI_W-1:0]               idx,
        input logic                          need,
        input logic [REG_NUM-1:0][XLEN-1:0]  vals,
        input logic [REG_NUM-1:0]            busys,
        input logic [REG_NUM-1:0][ROB_W-1:0] tags,
        input logic [COMMIT_LANES-1:0]       en,
        input logic [COMMIT_LANES*RI_W-1:0]  cidx,
        input logic [COMMIT_LANES*ROB_W-1:0] ctag,
        input logic [COMMIT_LANES*XLEN-1:0]  cval
    );
        opnd_t r;
        r.value = vals[idx];
        r.busy  = 1'b0;
        r.tag   = '0;
        if (need) begin
            if (idx == '0) begin
                r.value = '0;
            end else begin
                r.busy = busys[idx];
                r.tag  = busys[idx] ? tags[idx] : '0;
                for (int k = 0; k < COMMIT_LANES; k++) begin
                    if (en[k] && cidx[k*RI_W +: RI_W] == idx && busys[idx] &&
                        ctag[k*ROB_W +: ROB_W] == tags[idx]) begin
                        r.value = cval[k*XLEN +: XLEN];
                        r.busy  = 1'b0;
                        r.tag   = '0;
                    end
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        rs1_op = lookup(dec_rs1_idx, dec_need_rs1, val_q, busy_q, tag_q,
                        cm_en, cm_idx, cm_tag, cm_value);
        rs2_op = lookup(dec_rs2_idx, dec_need_rs2, val_q, busy_q, tag_q,
                        cm_en, cm_idx, cm_tag, cm_value);
    end

    // Next state: commits first, then flush or rename override the busy/tag view.
    always_comb begin
        val_n  = val_q;
        busy_n = busy_q;
        tag_n  = tag_q;
        ci     = '0;
        ct     = '0;
        for (int k = 0; k < COMMIT_LANES; k++) begin
            ci = cm_idx[k*RI_W +: RI_W];
            ct = cm_tag[k*ROB_W +: ROB_W];
            if (cm_en[k] && ci != '0) begin
                val_n[ci] = cm_value[k*XLEN +: XLEN];
                if (busy_q[ci] && tag_q[ci] == ct) begin
                    busy_n[ci] = 1'b0;
                    tag_n[ci]  = '0;
                end
            end
        end
        if (jump_wrong) begin
            busy_n = '0;
            tag_n  = '0;
        end else if (accept && dec_has_rd && dec_rd_idx != '0) begin
            busy_n[dec_rd_idx] = 1'b1;
            tag_n[dec_rd_idx]  = dec_rob_tag;
        end
    end

    // ---- stage p1: state update and registered response ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val_q  <= '0;
            busy_q <= '0;
            tag_q  <= '0;
            vld_p1 <= 1'b0;
            rs1_p1 <= '0;
            rs2_p1 <= '0;
        end else if (rdy) begin
            val_q  <= val_n;
            busy_q <= busy_n;
            tag_q  <= tag_n;
            vld_p1 <= accept;
            if (accept) begin
                rs1_p1 <= rs1_op;
                rs2_p1 <= rs2_op;
            end
        end
    end

    assign rsp_valid     = vld_p1;
    assign rsp_rs1_value = rs1_p1.value;
    assign rsp_rs1_busy  = rs1_p1.busy;
    assign rsp_rs1_tag   = rs1_p1.tag;
    assign rsp_rs2_value = rs2_p1.value;
    assign rsp_rs2_busy  = rs2_p1.busy;
    assign rsp_rs2_tag   = rs2_p1.tag;

endmodule

// File: tb/tb_rename_reg_file_mc.sv
// Randomised and directed bench for rename_reg_file_mc against a behavioural
// register-file model with a per-cycle response compare.
module tb_rename_reg_file_mc;

    localparam int XLEN = 32;
    localparam int REG_NUM = 32;
    localparam int ROB_W = 4;
    localparam int NL = 2;
    localparam int RI_W = 5;

    logic clk = 1'b0;
    logic rst, rdy, jump_wrong, dec_valid;
    logic [RI_W-1:0] dec_rs1_idx, dec_rs2_idx, dec_rd_idx;
    logic dec_need_rs1, dec_need_rs2, dec_has_rd;
    logic [ROB_W-1:0] dec_rob_tag;
    logic rsp_valid, rsp_rs1_busy, rsp_rs2_busy;
    logic [XLEN-1:0] rsp_rs1_value, rsp_rs2_value;
    logic [ROB_W-1:0] rsp_rs1_tag, rsp_rs2_tag;
    logic [NL-1:0] cm_en;
    logic [NL*RI_W-1:0] cm_idx;
    logic [NL*ROB_W-1:0] cm_tag;
    logic [NL*XLEN-1:0] cm_value;

    logic            cl_en  [NL];
    logic [RI_W-1:0] cl_idx [NL];
    logic [ROB_W-1:0] cl_tag [NL];
    logic [XLEN-1:0] cl_val [NL];

    assign cm_en    = {cl_en[1], cl_en[0]};
    assign cm_idx   = {cl_idx[1], cl_idx[0]};
    assign cm_tag   = {cl_tag[1], cl_tag[0]};
    assign cm_value = {cl_val[1], cl_val[0]};

    rename_reg_file_mc dut (
        .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
        .dec_valid(dec_valid), .dec_rs1_idx(dec_rs1_idx), .dec_rs2_idx(dec_rs2_idx),
        .dec_need_rs1(dec_need_rs1), .dec_need_rs2(dec_need_rs2),
        .dec_rd_idx(dec_rd_idx), .dec_has_rd(dec_has_rd), .dec_rob_tag(dec_rob_tag),
        .rsp_valid(rsp_valid), .rsp_rs1_value(rsp_rs1_value), .rsp_rs1_busy(rsp_rs1_busy),
        .rsp_rs1_tag(rsp_rs1_tag), .rsp_rs2_value(rsp_rs2_value), .rsp_rs2_busy(rsp_rs2_busy),
        .rsp_rs2_tag(rsp_rs2_tag), .cm_en(cm_en), .cm_idx(cm_idx), .cm_tag(cm_tag),
        .cm_value(cm_value)
    );

    always #5 clk = ~clk;

    // Behavioural model of the architectural state and the pending response.
    logic [XLEN-1:0]  mval  [REG_NUM];
    bit               mbusy [REG_NUM];
    logic [ROB_W-1:0] mtag  [REG_NUM];
    bit               e_vld;
    logic [XLEN-1:0]  e_v1, e_v2;
    bit               e_b1, e_b2;
    logic [ROB_W-1:0] e_t1, e_t2;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < REG_NUM; i++) begin
            mval[i] = '0; mbusy[i] = 0; mtag[i] = '0;
        end
        e_vld = 0; e_v1 = '0; e_v2 = '0; e_b1 = 0; e_b2 = 0; e_t1 = '0; e_t2 = '0;
    endtask

    function automatic void mlook(input logic [RI_W-1:0] idx, input bit need,
                                  output logic [XLEN-1:0] v, output bit b,
                                  output logic [ROB_W-1:0] t);
        v = mval[idx]; b = 0; t = '0;
        if (!need) return;
        if (idx == 0) begin v = '0; return; end
        b = mbusy[idx];
        t = b ? mtag[idx] : '0;
        for (int k = NL - 1; k >= 0; k--) begin
            if (cl_en[k] && cl_idx[k] == idx && mbusy[idx] && cl_tag[k] == mtag[idx]) begin
                v = cl_val[k]; b = 0; t = '0;
                break;
            end
        end
    endfunction

    task automatic clr_in();
        rdy = 1; jump_wrong = 0; dec_valid = 0;
        dec_rs1_idx = '0; dec_rs2_idx = '0; dec_rd_idx = '0;
        dec_need_rs1 = 0; dec_need_rs2 = 0; dec_has_rd = 0; dec_rob_tag = '0;
        for (int k = 0; k < NL; k++) begin
            cl_en[k] = 0; cl_idx[k] = '0; cl_tag[k] = '0; cl_val[k] = '0;
        end
    endtask

    task automatic req(input int rs1, input int rs2, input bit n1, input bit n2,
                       input int rd, input bit hrd, input int tag);
        dec_valid = 1;
        dec_rs1_idx = RI_W'(rs1); dec_rs2_idx = RI_W'(rs2);
        dec_need_rs1 = n1; dec_need_rs2 = n2;
        dec_rd_idx = RI_W'(rd); dec_has_rd = hrd; dec_rob_tag = ROB_W'(tag);
    endtask

    task automatic cm(input int lane, input int idx, input int tag, input logic [31:0] val);
        cl_en[lane] = 1; cl_idx[lane] = RI_W'(idx); cl_tag[lane] = ROB_W'(tag); cl_val[lane] = val;
    endtask

    // Advance one clock: update the model from current inputs, then compare.
    task automatic tick();
        logic [XLEN-1:0] v1, v2;
        bit b1, b2;
        logic [ROB_W-1:0] t1, t2;
        logic [XLEN-1:0]  nval [REG_NUM];
        bit               nbusy [REG_NUM];
        logic [ROB_W-1:0] ntag [REG_NUM];
        if (rdy) begin
            mlook(dec_rs1_idx, dec_need_rs1, v1, b1, t1);
            mlook(dec_rs2_idx, dec_need_rs2, v2, b2, t2);
            e_vld = dec_valid && !jump_wrong;
            if (e_vld) begin
                e_v1 = v1; e_b1 = b1; e_t1 = t1;
                e_v2 = v2; e_b2 = b2; e_t2 = t2;
            end
            nval = mval; nbusy = mbusy; ntag = mtag;
            for (int k = 0; k < NL; k++) begin
                if (cl_en[k] && cl_idx[k] != 0) begin
                    nval[cl_idx[k]] = cl_val[k];
                    if (mbusy[cl_idx[k]] && mtag[cl_idx[k]] == cl_tag[k]) begin
                        nbusy[cl_idx[k]] = 0;
                        ntag[cl_idx[k]] = '0;
                    end
                end
            end
            if (jump_wrong) begin
                for (int i = 0; i < REG_NUM; i++) begin nbusy[i] = 0; ntag[i] = '0; end
            end else if (dec_valid && dec_has_rd && dec_rd_idx != 0) begin
                nbusy[dec_rd_idx] = 1;
                ntag[dec_rd_idx] = dec_rob_tag;
            end
            mval = nval; mbusy = nbusy; mtag = ntag;
        end
        @(posedge clk);
        #1;
        check("rsp_valid", 32'(rsp_valid), 32'(e_vld));
        if (e_vld) begin
            check("rs1_value", rsp_rs1_value, e_v1);
            check("rs1_busy", 32'(rsp_rs1_busy), 32'(e_b1));
            check("rs1_tag", 32'(rsp_rs1_tag), 32'(e_t1));
            check("rs2_value", rsp_rs2_value, e_v2);
            check("rs2_busy", 32'(rsp_rs2_busy), 32'(e_b2));
            check("rs2_tag", 32'(rsp_rs2_tag), 32'(e_t2));
        end
    endtask

    initial begin
        clr_in();
        rst = 0;
        model_reset();
        #12;
        check("reset_valid", 32'(rsp_valid), 32'd0);
        check("reset_rs1_value", rsp_rs1_value, 32'd0);
        check("reset_rs2_tag", 32'(rsp_rs2_tag), 32'd0);
        @(posedge clk); #1;
        rst = 1;

        // Basic lookup after reset
        req(5, 6, 1, 1, 0, 0, 0); tick();
        check("lit_first_valid", 32'(rsp_valid), 32'd1);
        check("lit_first_v1", rsp_rs1_value, 32'd0);
        check("lit_first_b2", 32'(rsp_rs2_busy), 32'd0);
        clr_in(); tick();
        check("lit_second_valid", 32'(rsp_valid), 32'd0);

        // Rename then commit with bypass
        req(0, 0, 0, 0, 5, 1, 3); tick();
        clr_in(); req(5, 0, 1, 0, 0, 0, 0); tick();
        check("lit_x5_busy", 32'(rsp_rs1_busy), 32'd1);
        check("lit_x5_tag", 32'(rsp_rs1_tag), 32'd3);
        clr_in(); cm(0, 5, 3, 32'hDEAD_BEEF); req(5, 0, 1, 0, 0, 0, 0); tick();
        check("lit_bypass_val", rsp_rs1_value, 32'hDEAD_BEEF);
        check("lit_bypass_busy", 32'(rsp_rs1_busy), 32'd0);
        clr_in(); req(5, 0, 1, 0, 0, 0, 0); tick();
        check("lit_x5_after_busy", 32'(rsp_rs1_busy), 32'd0);
        check("lit_x5_after_val", rsp_rs1_value, 32'hDEAD_BEEF);

        // Stale-tag commit leaves newer rename intact
        clr_in(); req(0, 0, 0, 0, 7, 1, 2); tick();
        clr_in(); req(0, 0, 0, 0, 7, 1, 9); tick();
        clr_in(); cm(0, 7, 2, 32'h11); tick();
        clr_in(); req(0, 7, 0, 1, 0, 0, 0); tick();
        check("lit_stale_busy", 32'(rsp_rs2_busy), 32'd1);
        check("lit_stale_tag", 32'(rsp_rs2_tag), 32'd9);
        check("lit_stale_val", rsp_rs2_value, 32'h11);

        // Two lanes commit the same register; only lane 1 owns the tag
        clr_in(); req(0, 0, 0, 0, 4, 1, 4); tick();
        clr_in(); cm(0, 4, 1, 32'hA); cm(1, 4, 4, 32'hB); req(4, 0, 1, 0, 0, 0, 0); tick();
        check("lit_lane_val", rsp_rs1_value, 32'hB);
        check("lit_lane_busy", 32'(rsp_rs1_busy), 32'd0);
        clr_in(); req(4, 0, 1, 0, 0, 0, 0); tick();
        check("lit_lane_stored", rsp_rs1_value, 32'hB);

        // rs==rd sees old mapping; flush drops request but keeps commit value
        clr_in(); req(8, 0, 1, 0, 8, 1, 6); tick();
        check("lit_self_busy", 32'(rsp_rs1_busy), 32'd0);
        clr_in(); req(8, 0, 1, 0, 0, 0, 0); tick();
        check("lit_x8_tag", 32'(rsp_rs1_tag), 32'd6);
        clr_in(); jump_wrong = 1; req(8, 0, 1, 0, 3, 1, 2); cm(0, 8, 0, 32'h55); tick();
        check("lit_flush_valid", 32'(rsp_valid), 32'd0);
        clr_in(); req(8, 3, 1, 1, 0, 0, 0); tick();
        check("lit_flush_busy", 32'(rsp_rs1_busy), 32'd0);
        check("lit_flush_val", rsp_rs1_value, 32'h55);
        check("lit_flush_rd_dropped", 32'(rsp_rs2_busy), 32'd0);

        // rdy low freezes state and response
        clr_in(); req(0, 0, 0, 0, 9, 1, 5); tick();
        clr_in(); req(9, 0, 1, 0, 0, 0, 0); tick();
        clr_in(); rdy = 0; req(9, 9, 1, 1, 9, 1, 1); cm(0, 9, 5, 32'h77);
        tick(); tick(); tick();
        check("lit_hold_valid", 32'(rsp_valid), 32'd1);
        check("lit_hold_tag", 32'(rsp_rs1_tag), 32'd5);
        clr_in(); req(9, 0, 1, 0, 0, 0, 0); tick();
        check("lit_hold_busy", 32'(rsp_rs1_busy), 32'd1);
        check("lit_hold_tag2", 32'(rsp_rs1_tag), 32'd5);
        check("lit_hold_val", rsp_rs1_value, 32'd0);

        // Register 0 never renamed or written
        clr_in(); req(0, 0, 0, 0, 0, 1, 7); cm(0, 0, 0, 32'h99); tick();
        clr_in(); req(0, 0, 1, 1, 0, 0, 0); tick();
        check("lit_x0_val", rsp_rs1_value, 32'd0);
        check("lit_x0_busy", 32'(rsp_rs2_busy), 32'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            clr_in();
            rdy = ($urandom_range(0, 9) != 0);
            jump_wrong = ($urandom_range(0, 19) == 0);
            dec_valid = ($urandom_range(0, 9) < 7);
            dec_rs1_idx = RI_W'($urandom_range(0, 7));
            dec_rs2_idx = RI_W'($urandom_range(0, 7));
            dec_need_rs1 = $urandom_range(0, 1);
            dec_need_rs2 = $urandom_range(0, 1);
            dec_rd_idx = RI_W'($urandom_range(0, 7));
            dec_has_rd = $urandom_range(0, 1);
            dec_rob_tag = ROB_W'($urandom);
            for (int k = 0; k < NL; k++) begin
                cl_en[k] = $urandom_range(0, 1);
                cl_idx[k] = RI_W'($urandom_range(0, 7));
                cl_tag[k] = ($urandom_range(0, 1) != 0) ? mtag[cl_idx[k]] : ROB_W'($urandom);
                cl_val[k] = $urandom;
            end
            tick();
        end

        // Asynchronous reset mid-sequence
        clr_in(); req(0, 0, 0, 0, 6, 1, 11); tick();
        clr_in(); req(6, 0, 1, 0, 0, 0, 0); cl_val[0] = 32'h1; tick();
        #2;
        rst = 0;
        #1;
        check("async_valid", 32'(rsp_valid), 32'd0);
        check("async_busy", 32'(rsp_rs1_busy), 32'd0);
        check("async_tag", 32'(rsp_rs1_tag), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1;
        clr_in(); req(6, 5, 1, 1, 0, 0, 0); tick();
        check("lit_post_rst_busy", 32'(rsp_rs1_busy), 32'd0);
        check("lit_post_rst_val", rsp_rs2_value, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
